// File: rtl/dff_sync.sv
// dff_sync: parameterised D register chain with complementary outputs.
// STAGES cascaded WIDTH-bit registers; q is the last stage, qb its inverse.
module dff_sync #(
    parameter int unsigned          WIDTH   = 1,
    parameter int unsigned          STAGES  = 1,
    parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    logic [WIDTH-1:0] r_stage [STAGES];
    logic [WIDTH-1:0] w_last;

    // Shift the chain each edge; synchronous reset loads every stage and wins over data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_stage[i] <= RST_VAL;
            end
        end else begin
            r_stage[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    // Outputs come straight from the final stage; qb has no storage of its own.
    always_comb begin
        w_last = r_stage[STAGES-1];
        q      = w_last;
        qb     = ~w_last;
    end

endmodule

// File: tb/tb_dff_sync.sv
// tb_dff_sync: checks a default 1-bit instance and an 8-bit, 3-stage,
// reset-value-A5 instance against an edge-history reference model.
module tb_dff_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       d1;
    logic [7:0] d8;
    logic       q1, qb1;
    logic [7:0] q8, qb8;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: value of d captured at each rising edge, and the
    // index of the most recent edge at which reset was high.
    logic       h1[$];
    logic [7:0] h8[$];
    int         e        = -1;
    int         last_rst = -1;

    always #5 clk = ~clk;

    dff_sync u_dff1 (
        .clk (clk),
        .rst (rst),
        .d   (d1),
        .q   (q1),
        .qb  (qb1)
    );

    dff_sync #(
        .WIDTH   (8),
        .STAGES  (3),
        .RST_VAL (8'hA5)
    ) u_dff8 (
        .clk (clk),
        .rst (rst),
        .d   (d8),
        .q   (q8),
        .qb  (qb8)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, e);
    endtask

    // q after edge e is the d captured STAGES-1 edges earlier, unless a
    // reset edge happened at or after that capture.
    function automatic logic model1();
        int src = e;
        if (src <= last_rst) return 1'b0;
        return h1[src];
    endfunction

    function automatic logic [7:0] model8();
        int src = e - 2;
        if (src <= last_rst) return 8'hA5;
        return h8[src];
    endfunction

    task automatic check_all(input string ph);
        logic       m1;
        logic [7:0] m8;
        m1 = model1();
        m8 = model8();
        check({ph, "_q1"},  {7'b0, q1},  {7'b0, m1});
        check({ph, "_qb1"}, {7'b0, qb1}, {7'b0, ~m1});
        check({ph, "_q8"},  q8,  m8);
        check({ph, "_qb8"}, qb8, ~m8);
    endtask

    // Drive inputs at the falling edge, confirm outputs have not moved,
    // take the rising edge, update the model, check, then wiggle d mid-high.
    task automatic step(input logic r, input logic dv1, input logic [7:0] dv8);
        @(negedge clk);
        rst = r;
        d1  = dv1;
        d8  = dv8;
        #1;
        if (last_rst >= 0) check_all("hold");
        @(posedge clk);
        e++;
        h1.push_back(dv1);
        h8.push_back(dv8);
        if (r) last_rst = e;
        #1;
        check_all("edge");
        #1;
        d1 = ~dv1;
        d8 = 8'($urandom);
    endtask

    initial begin
        rst = 1'b0;
        d1  = 1'bx;
        d8  = 'x;

        // Reset with unknown data, then release and capture.
        step(1'b1, 1'bx, 8'hxx);
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b0, 8'h02);
        step(1'b0, 1'b1, 8'h03);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        // Reset asserted with d=1: hold check sees old q, edge clears.
        step(1'b1, 1'b1, 8'h44);
        step(1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b0, 8'h22);
        // Reset mid-stream on the 8-bit chain discards in-flight data.
        step(1'b1, 1'b1, 8'h33);
        step(1'b0, 1'b1, 8'h55);
        step(1'b0, 1'b1, 8'h66);
        step(1'b0, 1'b0, 8'h77);

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 7) == 0), 1'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
